// File: rtl/fir_coef_loader.sv
// ============================================================================
// Module   : fir_coef_loader
// Brief    : Streams FIR taps into a shadow register and commits them
//            atomically onto the parallel coefficient bus on a sample enable.
//            Optional checksum word enabled by FIR_COEF_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_coef_loader #(
    parameter int DELAYS = 3,
    parameter int N      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [N-1:0]            coef_in,
    input  logic                    coef_valid,
    output logic                    coef_ready,
    input  logic                    ena,
    output logic [(DELAYS+1)*N-1:0] b_out,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int                c_NTAPS = DELAYS + 1;
    localparam int                c_IDXW  = $clog2(c_NTAPS);
    localparam logic [c_IDXW-1:0] c_LAST  = c_IDXW'(DELAYS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2
`ifdef FIR_COEF_CHECKSUM_EN
        , S_CHECK = 2'd3
`endif
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_IDXW-1:0]       r_idx;
    logic [N-1:0]            r_shadow [c_NTAPS];
    logic [c_NTAPS*N-1:0]    w_shadow_flat;
    logic [c_NTAPS*N-1:0]    r_b_out;
    logic                    w_ready;
    logic                    w_wr;
    logic                    w_commit;
    logic                    w_err;
`ifdef FIR_COEF_CHECKSUM_EN
    logic [N-1:0]            r_sum;
`endif

    for (genvar k = 0; k < c_NTAPS; k++) begin : g_pack
        assign w_shadow_flat[k*N +: N] = r_shadow[k];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_wr        = 1'b0;
        w_commit    = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_ready = 1'b1;
                // Abort beats a simultaneous handshake; that word is dropped.
                if (abort) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (coef_valid) begin
                    w_wr = 1'b1;
                    if (r_idx == c_LAST) begin
`ifdef FIR_COEF_CHECKSUM_EN
                        w_state_nxt = S_CHECK;
`else
                        w_state_nxt = S_COMMIT;
`endif
                    end
                end
            end
`ifdef FIR_COEF_CHECKSUM_EN
            S_CHECK: begin
                w_ready = 1'b1;
                if (abort) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (coef_valid) begin
                    if (coef_in == r_sum) begin
                        w_state_nxt = S_COMMIT;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
`endif
            S_COMMIT: begin
                if (ena) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_b_out <= '0;
            for (int k = 0; k < c_NTAPS; k++) r_shadow[k] <= '0;
`ifdef FIR_COEF_CHECKSUM_EN
            r_sum   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && start) begin
                r_idx <= '0;
`ifdef FIR_COEF_CHECKSUM_EN
                r_sum <= '0;
`endif
            end
            if (w_wr) begin
                r_shadow[r_idx] <= coef_in;
                // Hold on the last tap so the index never exceeds DELAYS.
                if (r_idx != c_LAST) r_idx <= r_idx + c_IDXW'(1);
`ifdef FIR_COEF_CHECKSUM_EN
                r_sum <= r_sum + coef_in;
`endif
            end
            if (w_commit) r_b_out <= w_shadow_flat;
        end
    end

    // Pulses are masked during reset so no strobe escapes without its effect.
    assign coef_ready = w_ready;
    assign busy       = (r_state != S_IDLE);
    assign done       = w_commit & ~rst;
    assign err        = w_err & ~rst;
    assign b_out      = r_b_out;

endmodule

`default_nettype wire

// File: doc/fir_coef_loader.md
Name: fir_coef_loader

Overview:
Writer side of the FIR coefficient bus. It accepts filter taps one word at a time over a valid/ready stream and assembles them in a shadow register. It then commits the full set atomically onto the parallel (DELAYS+1)*N coefficient bus that feeds the fir_n tap inputs, so the filter never sees a half-updated tap set. The block sits between the host/config path and the filter instance.

Parameters:
DELAYS, 3, number of delay blocks in the target filter; tap count = DELAYS+1; must be >= 2
N, 32, coefficient word width in bits

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a new load; honoured only in IDLE
abort  input  1  cancels a load in progress; honoured only in LOAD (and CHECK when the macro is enabled)
coef_in  input  N  coefficient word, tap 0 first
coef_valid  input  1  coef_in holds a valid word
coef_ready  output  1  loader accepts a word this cycle
ena  input  1  filter sample enable; commit happens only in a cycle with ena=1
b_out  output  (DELAYS+1)*N  committed coefficients; tap k at bits [(k+1)*N-1 : k*N]
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse in the cycle b_out updates
err  output  1  one-cycle pulse on abort (or on checksum mismatch when the macro is enabled)

Behaviour:
- Reset (rst=1 at clk edge) forces the following, regardless of the current state:
  - state=IDLE, idx=0, shadow=0, b_out=0
  - coef_ready=0, busy=0, done=0, err=0
- States are IDLE, LOAD, COMMIT, plus CHECK only when the macro is enabled.
- IDLE:
  - coef_ready=0.
  - start=1 sets idx to 0 and moves to LOAD on the next cycle.
  - abort is ignored.
- LOAD:
  - coef_ready=1.
  - A handshake is coef_valid & coef_ready. It writes shadow tap[idx] <= coef_in and increments idx.
  - The handshake at idx==DELAYS moves to COMMIT (or to CHECK when the macro is enabled). coef_ready drops the following cycle.
  - No back-pressure beyond state: every valid word in LOAD is accepted, one per cycle.
  - start is ignored.
- COMMIT:
  - coef_ready=0.
  - Waits for ena=1. In that cycle b_out <= shadow (all taps at once), done pulses for exactly that cycle, and the next state is IDLE.
  - If ena is already 1 on COMMIT entry, the commit happens on the first COMMIT cycle.
  - abort and start are ignored.
- Abort in LOAD:
  - Next state is IDLE; err pulses for one cycle; b_out is unchanged; the shadow contents are don't-care.
  - If abort and a handshake occur in the same cycle, abort wins and the word is discarded. The word is still considered consumed: coef_ready was 1.
- Latency:
  - start to first coef_ready: 1 cycle.
  - Last handshake to b_out update: at least 1 cycle (COMMIT entry), then until ena=1.
- Data path:
  - b_out is held constant except at commit.
  - Data is stored and passed raw; no arithmetic on coefficients in the data path.
  - idx width is clog2(DELAYS+1), and idx never exceeds DELAYS.
- busy=1 in LOAD, COMMIT and CHECK; the next start is accepted only once busy=0.

Optional Feature:
Macro FIR_COEF_CHECKSUM_EN.
- Defined:
  - After the last tap, the FSM enters CHECK with coef_ready=1 and accepts one more word: the checksum, equal to the sum of all DELAYS+1 taps modulo 2^N.
  - The running sum is accumulated during LOAD in an N-bit register that wraps and is cleared on start.
  - If the checksum matches, go to COMMIT.
  - If it mismatches, err pulses, the FSM returns to IDLE and b_out is unchanged.
  - abort in CHECK behaves as abort in LOAD.
- Undefined: no CHECK state and no sum register; the last tap goes directly to COMMIT.

Test Plan:
1. Reset, then DELAYS=3, N=32: start, then words 1,2,3,4 back-to-back with ena=1 -> coef_ready high for 4 cycles; done pulses 1 cycle after the 4th handshake; b_out=0x00000004_00000003_00000002_00000001; busy then returns to 0.
2. Same load with ena held 0 for 5 cycles after the last word -> b_out stays 0 and busy=1 throughout; b_out updates with done in the first cycle ena=1.
3. Load 5,6,7,8 committed; start a new load and send 9,10, then abort together with the 3rd word -> err pulse, no done, b_out remains 8,7,6,5 (tap3..tap0); the next full load succeeds normally.
4. rst asserted mid-LOAD after 2 words -> the next cycle shows b_out=0, busy=0, coef_ready=0; a start pulse in LOAD is ignored (idx is not reset); coef_valid=1 while in IDLE yields no handshake.
5. With FIR_COEF_CHECKSUM_EN: taps 0xFFFFFFFF,1,2,3 with checksum 5 -> commit (sum wraps); the same taps with checksum 6 -> err pulse, b_out unchanged.
